// File: rtl/term_writer_pkg.sv
// Shared constants, FSM state type and mod-ROWS row helpers for the terminal writer.
// Default geometry matches the VRAM/HDMI character renderer.
package term_writer_pkg;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    localparam int DEF_COLS     = 80;
    localparam int DEF_ROWS     = 25;
    localparam int DEF_TAB_STOP = 8;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_TAB   = 8'h09;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL  = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLEAR_WAIT = 2'd2,
        ST_CLEAR_LINE = 2'd3
    } state_t;

    // Rows never reach 32, so a 6-bit sum with one conditional subtract is exact mod rows.
    function automatic logic [4:0] row_add(input logic [4:0] a, input logic [4:0] b,
                                           input int rows);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(rows))
            s = s - 6'(rows);
        return s[4:0];
    endfunction

endpackage

// File: rtl/term_writer_clear_sweep.sv
// Row/column sweep counter that emits the cell addresses for a full-screen or single-line clear.
// busy doubles as the write strobe; done marks the final cell of the sweep.
module term_writer_clear_sweep
    import term_writer_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       start,
    input  logic       all_rows,
    input  logic [4:0] start_row,
    output logic       busy,
    output logic       done,
    output logic [4:0] row,
    output logic [6:0] col
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic all_mode;

    assign done = busy && (col == LAST_COL) && (!all_mode || (row == LAST_ROW));

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            busy     <= 1'b0;
            all_mode <= 1'b0;
            row      <= '0;
            col      <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            all_mode <= all_rows;
            row      <= all_rows ? 5'd0 : start_row;
            col      <= '0;
        end else if (busy) begin
            if (col == LAST_COL) begin
                col <= '0;
                if (done)
                    busy <= 1'b0;
                else
                    row <= row + 5'd1;
            end else begin
                col <= col + 7'd1;
            end
        end
    end

endmodule

// File: rtl/term_writer.sv
// Byte-stream terminal front end: cursor handling, C0 controls, circular scroll and VRAM writes.
// Optional form-feed support is enabled by defining TERM_WRITER_FORM_FEED_EN.
//
// state         | meaning
// ST_CLEAR_ALL  | sweep spaces over every cell, cursor and top_row held at 0
// ST_IDLE       | in_ready=1, interpret one byte per cycle
// ST_CLEAR_WAIT | one-cycle gap so a wrapping char write precedes the line clear
// ST_CLEAR_LINE | sweep spaces over the newly exposed bottom physical row
module term_writer
    import term_writer_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int TAB_STOP = DEF_TAB_STOP
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    output logic       write_ce,
    output logic [4:0] write_row,
    output logic [6:0] write_col,
    output logic [7:0] write_char,
    output logic [4:0] top_row,
    output logic [4:0] cursor_row,
    output logic [6:0] cursor_col
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0] TAB_MASK = ~8'(TAB_STOP - 1);

    state_t     state;
    logic [4:0] line_row;
    logic       char_ce;
    logic [4:0] char_row;
    logic [6:0] char_col;
    logic [7:0] char_byte;

    logic       sweep_start, sweep_all, sweep_busy, sweep_done;
    logic [4:0] sweep_start_row, sweep_row;
    logic [6:0] sweep_col;

    logic       accept, is_print, at_bottom;
    logic [7:0] tab_raw;
    logic [6:0] tab_next;

    assign accept    = in_valid && in_ready;
    assign is_print  = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign at_bottom = (cursor_row == LAST_ROW);

    always_comb begin
        tab_raw  = ({1'b0, cursor_col} & TAB_MASK) + 8'(TAB_STOP);
        tab_next = (tab_raw > {1'b0, LAST_COL}) ? LAST_COL : tab_raw[6:0];
    end

    // A bare LF at the bottom starts the line clear on the acceptance edge itself.
    assign sweep_start = ((state == ST_CLEAR_ALL) && !sweep_busy) ||
                         (state == ST_CLEAR_WAIT) ||
                         (accept && (state == ST_IDLE) && (in_char == CHAR_LF) && at_bottom);
    assign sweep_all       = (state == ST_CLEAR_ALL);
    assign sweep_start_row = (state == ST_CLEAR_WAIT) ? line_row : top_row;

    term_writer_clear_sweep #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
        .clk       (clk),
        .reset_low (reset_low),
        .start     (sweep_start),
        .all_rows  (sweep_all),
        .start_row (sweep_start_row),
        .busy      (sweep_busy),
        .done      (sweep_done),
        .row       (sweep_row),
        .col       (sweep_col)
    );

    assign write_ce   = char_ce || sweep_busy;
    assign write_row  = sweep_busy ? sweep_row : char_row;
    assign write_col  = sweep_busy ? sweep_col : char_col;
    assign write_char = sweep_busy ? CHAR_SPACE : char_byte;

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            state      <= ST_CLEAR_ALL;
            in_ready   <= 1'b0;
            top_row    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            line_row   <= '0;
            char_ce    <= 1'b0;
            char_row   <= '0;
            char_col   <= '0;
            char_byte  <= '0;
        end else begin
            char_ce <= 1'b0;
            case (state)
                ST_CLEAR_ALL, ST_CLEAR_LINE: begin
                    if (sweep_done) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end
                end
                ST_CLEAR_WAIT: state <= ST_CLEAR_LINE;
                ST_IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            char_ce   <= 1'b1;
                            char_row  <= row_add(top_row, cursor_row, ROWS);
                            char_col  <= cursor_col;
                            char_byte <= in_char;
                            if (cursor_col < LAST_COL) begin
                                cursor_col <= cursor_col + 7'd1;
                            end else begin
                                cursor_col <= '0;
                                if (!at_bottom) begin
                                    cursor_row <= cursor_row + 5'd1;
                                end else begin
                                    top_row  <= row_add(top_row, 5'd1, ROWS);
                                    line_row <= top_row;
                                    in_ready <= 1'b0;
                                    state    <= ST_CLEAR_WAIT;
                                end
                            end
                        end else begin
                            case (in_char)
                                CHAR_CR: cursor_col <= '0;
                                CHAR_LF: begin
                                    if (!at_bottom) begin
                                        cursor_row <= cursor_row + 5'd1;
                                    end else begin
                                        top_row  <= row_add(top_row, 5'd1, ROWS);
                                        in_ready <= 1'b0;
                                        state    <= ST_CLEAR_LINE;
                                    end
                                end
                                CHAR_BS: begin
                                    if (cursor_col != '0)
                                        cursor_col <= cursor_col - 7'd1;
                                end
                                CHAR_TAB: cursor_col <= tab_next;
`ifdef TERM_WRITER_FORM_FEED_EN
                                CHAR_FF: begin
                                    cursor_row <= '0;
                                    cursor_col <= '0;
                                    top_row    <= '0;
                                    in_ready   <= 1'b0;
                                    state      <= ST_CLEAR_ALL;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= ST_CLEAR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer at 80x25: clears, printing, controls, scroll, wrap and reset.
module tb_term_writer;

    logic       clk = 1'b0;
    logic       reset_low;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       write_ce;
    logic [4:0] write_row;
    logic [6:0] write_col;
    logic [7:0] write_char;
    logic [4:0] top_row;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_top;
    int old_top;
    bit bad;

    always #5 clk = ~clk;

    term_writer dut (
        .clk        (clk),
        .reset_low  (reset_low),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .write_ce   (write_ce),
        .write_row  (write_row),
        .write_col  (write_col),
        .write_char (write_char),
        .top_row    (top_row),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_char  = b;
        tick();
        in_valid = 1'b0;
        in_char  = 8'h00;
    endtask

    // Consumes samples from the current one until in_ready returns, checking every clear write.
    task automatic wait_clear(input string tag, input bit all_rows, input int row,
                              input int exp_n, input int exp_low);
        int n = 0;
        int low = 0;
        int cyc = 0;
        bit seq_bad = 0;
        int er, ec;
        while (in_ready !== 1'b1 && cyc < 2200) begin
            low++;
            if (write_ce === 1'b1) begin
                er = all_rows ? n / 80 : row;
                ec = all_rows ? n % 80 : n;
                if (write_row !== 5'(er) || write_col !== 7'(ec) || write_char !== 8'h20)
                    seq_bad = 1'b1;
                n++;
            end
            tick();
            cyc++;
        end
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_seq"}, seq_bad, 0);
        check({tag, "_writes"}, n, exp_n);
        check({tag, "_busy_cycles"}, low, exp_low);
    endtask

    initial begin
        reset_low = 1'b0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        repeat (3) tick();
        check("rst_write_ce", write_ce, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_top_row", top_row, 0);
        check("rst_cursor", {cursor_row, cursor_col}, 0);
        check("rst_write_addr", {write_row, write_col, write_char}, 0);

        reset_low = 1'b1;
        wait_clear("clear_all", 1'b1, 0, 2000, 2001);
        check("post_clear_top", top_row, 0);
        check("post_clear_cursor", {cursor_row, cursor_col}, 0);
        check("post_clear_idle_ce", write_ce, 0);

        // "AB" back-to-back
        in_valid = 1'b1;
        in_char  = "A";
        tick();
        check("ab_a_write", {write_ce, write_row, write_col, write_char}, {1'b1, 5'd0, 7'd0, 8'h41});
        check("ab_ready_held", in_ready, 1);
        in_char = "B";
        tick();
        check("ab_b_write", {write_ce, write_row, write_col, write_char}, {1'b1, 5'd0, 7'd1, 8'h42});
        check("ab_cursor_col", cursor_col, 2);
        in_valid = 1'b0;
        tick();
        check("ab_no_extra_write", write_ce, 0);

        // full row of 80 printables starting from col 0
        send(8'h0D);
        check("cr_col", cursor_col, 0);
        bad = 1'b0;
        for (int i = 0; i < 80; i++) begin
            send(8'h41 + 8'(i % 26));
            if (write_ce !== 1'b1 || write_row !== 5'd0 || write_col !== 7'(i) ||
                write_char !== 8'h41 + 8'(i % 26))
                bad = 1'b1;
        end
        check("row80_seq", bad, 0);
        check("row80_last_col", write_col, 79);
        check("row80_cursor", {cursor_row, cursor_col}, {5'd1, 7'd0});
        tick();
        check("row80_no_extra", write_ce, 0);
        check("row80_ready", in_ready, 1);

        // BS saturation, TAB stops and cap
        send("Q");
        check("q_write", {write_ce, write_row, write_col}, {1'b1, 5'd1, 7'd0});
        send(8'h08);
        check("bs1_col", cursor_col, 0);
        send(8'h08);
        check("bs2_sat_col", cursor_col, 0);
        check("bs_no_write", write_ce, 0);
        send(8'h09);
        check("tab1_col", cursor_col, 8);
        send("x");
        send("y");
        send("z");
        check("xyz_col", cursor_col, 11);
        send(8'h09);
        check("tab_mid_col", cursor_col, 16);
        for (int i = 0; i < 74; i++) send(8'h09);
        check("tab_cap_col", cursor_col, 79);
        check("tab_row", cursor_row, 1);

        // ignored control byte
        send(8'h01);
        check("ctl01_no_write", write_ce, 0);
        check("ctl01_cursor", {cursor_row, cursor_col}, {5'd1, 7'd79});

        // walk down to the bottom row, then scroll
        for (int i = 0; i < 23; i++) send(8'h0A);
        check("lf_bottom_row", cursor_row, 24);
        check("lf_no_scroll_top", top_row, 0);
        send(8'h0A);
        check("scroll_first_clear", {write_ce, write_row, write_col, write_char}, {1'b1, 5'd0, 7'd0, 8'h20});
        check("scroll_top", top_row, 1);
        check("scroll_cursor_row", cursor_row, 24);
        wait_clear("scroll_lf", 1'b0, 0, 80, 80);

        send(8'h0D);
        send("X");
        check("x_after_scroll", {write_ce, write_row, write_col, write_char}, {1'b1, 5'd0, 7'd0, 8'h58});

        // printable in the last column of the bottom row: char, then line clear
        for (int i = 0; i < 10; i++) send(8'h09);
        check("wrap_pre_col", cursor_col, 79);
        send("Z");
        check("wrap_char_write", {write_ce, write_row, write_col, write_char}, {1'b1, 5'd0, 7'd79, 8'h5A});
        check("wrap_in_ready", in_ready, 0);
        check("wrap_top", top_row, 2);
        check("wrap_cursor", {cursor_row, cursor_col}, {5'd24, 7'd0});
        tick();
        wait_clear("wrap_clear", 1'b0, 1, 80, 80);

        // 25 scrolls, passing the 24 -> 0 wrap of top_row
        exp_top = 2;
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            old_top = exp_top;
            exp_top = (exp_top + 1) % 25;
            send(8'h0A);
            if (top_row !== 5'(exp_top)) bad = 1'b1;
            wait_clear("lf_loop", 1'b0, old_top, 80, 80);
        end
        check("lf_loop_tops", bad, 0);
        check("lf_loop_final_top", top_row, 2);
        for (int i = 0; i < 5; i++) begin
            send(8'h0A);
            wait_clear("lf_to7", 1'b0, 2 + i, 80, 80);
        end
        check("top_seven", top_row, 7);

        send(8'h0D);
        send("k");
        send(8'h0C);
`ifdef TERM_WRITER_FORM_FEED_EN
        check("ff_top", top_row, 0);
        check("ff_cursor", {cursor_row, cursor_col}, 0);
        check("ff_ready", in_ready, 0);
        wait_clear("ff_clear", 1'b1, 0, 2000, 2001);
`else
        check("ff_ignored_write", write_ce, 0);
        check("ff_ignored_cursor", {cursor_row, cursor_col}, {5'd24, 7'd1});
        check("ff_ignored_top", top_row, 7);
        check("ff_ignored_ready", in_ready, 1);
`endif

        // reset during a line clear
        send(8'h0A);
        repeat (10) tick();
        check("midclr_busy", {write_ce, in_ready}, {1'b1, 1'b0});
        reset_low = 1'b0;
        tick();
        check("midclr_rst_ce", write_ce, 0);
        check("midclr_rst_outs", {in_ready, top_row, cursor_row, cursor_col, write_row, write_col, write_char}, 0);
        reset_low = 1'b1;
        wait_clear("midclr_restart", 1'b1, 0, 2000, 2001);
        check("midclr_final", {top_row, cursor_row, cursor_col}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
